// File: rtl/alu_flags_unit.sv
// alu_flags_unit: registered NZCV flags, sticky overflow, saturating overflow counter and branch-condition evaluation
module alu_flags_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             flag_we,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] result,
  input  logic             co_add,
  input  logic             co_prev_add,
  input  logic             co_sub,
  input  logic             co_prev_sub,
  input  logic             sv_clr,
  input  logic [3:0]       cond,
  output logic             c,
  output logic             n,
  output logic             z,
  output logic             v,
  output logic             sv,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic             out_valid,
  output logic             cond_true
);
  logic             upd, arith, c_nx, n_nx, z_nx, v_nx, ovf;
  logic             c_q, n_q, z_q, v_q, sv_q, ov_q;
  logic             c_d, n_d, z_d, v_d, sv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, base;
  assign upd   = in_valid & flag_we;
  assign arith = op[2:1] == 2'b11;
  assign n_nx  = result[WIDTH-1];
  assign z_nx  = result == '0;
  assign c_nx  = arith & (op[0] ? co_sub : co_add);
  assign v_nx  = arith & (op[0] ? co_sub ^ co_prev_sub : co_add ^ co_prev_add);
  assign ovf   = upd & v_nx;
  assign c_d   = upd ? c_nx : c_q;
  assign n_d   = upd ? n_nx : n_q;
  assign z_d   = upd ? z_nx : z_q;
  assign v_d   = upd ? v_nx : v_q;
  // a new overflow beats a simultaneous clear
  assign sv_d  = ovf | (sv_q & ~sv_clr);
  assign base  = sv_clr ? '0 : cnt_q;
  assign cnt_d = ovf && base != '1 ? base + CNT_W'(1) : base;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      {c_q, n_q, z_q, v_q, sv_q, ov_q} <= '0;
      cnt_q <= '0;
    end else begin
      {c_q, n_q, z_q, v_q, sv_q, ov_q} <= {c_d, n_d, z_d, v_d, sv_d, in_valid};
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'h0: cond_true = z_q;
      4'h1: cond_true = ~z_q;
      4'h2: cond_true = c_q;
      4'h3: cond_true = ~c_q;
      4'h4: cond_true = n_q;
      4'h5: cond_true = ~n_q;
      4'h6: cond_true = v_q;
      4'h7: cond_true = ~v_q;
      4'h8: cond_true = c_q & ~z_q;
      4'h9: cond_true = ~c_q | z_q;
      4'hA: cond_true = n_q == v_q;
      4'hB: cond_true = n_q != v_q;
      4'hC: cond_true = ~z_q & (n_q == v_q);
      4'hD: cond_true = z_q | (n_q != v_q);
      4'hE: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end
  assign {c, n, z, v, sv, out_valid} = {c_q, n_q, z_q, v_q, sv_q, ov_q};
  assign ovf_cnt = cnt_q;
endmodule

// File: tb/tb_alu_flags_unit.sv
// tb_alu_flags_unit: directed self-checking bench for alu_flags_unit
module tb_alu_flags_unit;
  logic        clk = 0, reset_n, in_valid, flag_we, co_add, co_prev_add, co_sub, co_prev_sub, sv_clr;
  logic [2:0]  op;
  logic [31:0] result;
  logic [3:0]  cond;
  logic        c, n, z, v, sv, out_valid, cond_true;
  logic [1:0]  ovf_cnt;
  logic [7:0]  o;
  int          tests = 0, fails = 0;

  alu_flags_unit #(.WIDTH(32), .CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .flag_we(flag_we), .op(op),
    .result(result), .co_add(co_add), .co_prev_add(co_prev_add), .co_sub(co_sub),
    .co_prev_sub(co_prev_sub), .sv_clr(sv_clr), .cond(cond), .c(c), .n(n), .z(z), .v(v),
    .sv(sv), .ovf_cnt(ovf_cnt), .out_valid(out_valid), .cond_true(cond_true)
  );

  always #5 clk = ~clk;
  assign o = {c, n, z, v, sv, ovf_cnt, out_valid};

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {in_valid, flag_we, co_add, co_prev_add, co_sub, co_prev_sub, sv_clr} = '0;
    op = 3'b000;
    result = '0;
  endtask

  task automatic drive(input logic [2:0] o_, input logic [31:0] r, input logic ca, cpa, cs, cps);
    in_valid = 1; flag_we = 1; op = o_; result = r;
    co_add = ca; co_prev_add = cpa; co_sub = cs; co_prev_sub = cps;
  endtask

  task automatic chk_o(input string name, input logic [7:0] exp);
    tests++;
    if (o !== exp) begin
      fails++;
      $display("FAIL %s: {c,n,z,v,sv,cnt,ov} got %b expected %b", name, o, exp);
    end
  endtask

  task automatic chk_cond(input string name, input logic [3:0] cc, input logic exp);
    cond = cc;
    #1;
    tests++;
    if (cond_true !== exp) begin
      fails++;
      $display("FAIL %s: cond %h cond_true got %b expected %b", name, cc, cond_true, exp);
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    drive(3'b110, 32'h8000_0000, 0, 1, 0, 0);
    edge_();
    edge_();
    chk_o("reset", 8'b0);
    chk_cond("reset_al", 4'hE, 1);
    chk_cond("reset_eq", 4'h0, 0);
    reset_n = 1;
    idle();
  endtask

  task automatic test_add_ovf();
    drive(3'b110, 32'h8000_0000, 0, 1, 0, 0);
    chk_cond("add_old_mi", 4'h4, 0);
    edge_();
    idle();
    chk_o("add_ovf", 8'b0101_1011);
    chk_cond("add_mi", 4'h4, 1);
    chk_cond("add_ge", 4'hA, 1);
    chk_cond("add_lt", 4'hB, 0);
  endtask

  task automatic test_sub_zero();
    drive(3'b111, 32'h0, 0, 0, 1, 1);
    edge_();
    idle();
    chk_o("sub_zero", 8'b1010_1011);
    chk_cond("sub_hi", 4'h8, 0);
    chk_cond("sub_ls", 4'h9, 1);
    chk_cond("sub_gt", 4'hC, 0);
    chk_cond("sub_le", 4'hD, 1);
  endtask

  task automatic test_logic_hold();
    drive(3'b000, 32'h0, 1, 0, 0, 0);
    edge_();
    chk_o("logic", 8'b0010_1011);
    chk_cond("logic_cc", 4'h3, 1);
    drive(3'b110, 32'h5, 0, 1, 0, 0);
    flag_we = 0;
    edge_();
    chk_o("hold", 8'b0010_1011);
    idle();
    edge_();
    chk_o("idle_ov", 8'b0010_1010);
  endtask

  task automatic test_cond_table();
    logic [15:0] exp = 16'h6A9A;
    drive(3'b000, 32'hFFFF_FFFF, 0, 0, 0, 0);
    edge_();
    idle();
    for (int i = 0; i < 16; i++) chk_cond("cond_table", 4'(i), exp[i]);
  endtask

  task automatic test_saturation();
    logic [1:0] exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    reset_n = 0;
    edge_();
    reset_n = 1;
    drive(3'b111, 32'h1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      edge_();
      chk_o("saturate", {4'b1001, 1'b1, exp[i], 1'b1});
    end
    sv_clr = 1;
    edge_();
    chk_o("clr_and_ovf", 8'b1001_1011);
    flag_we = 0;
    edge_();
    chk_o("clr_alone", 8'b1001_0001);
    idle();
  endtask

  task automatic test_reset_mid();
    drive(3'b110, 32'h8000_0000, 0, 1, 0, 0);
    edge_();
    chk_o("pre_reset", 8'b0101_1011);
    reset_n = 0;
    edge_();
    chk_o("reset_mid", 8'b0);
    reset_n = 1;
    drive(3'b111, 32'h0, 0, 0, 1, 1);
    edge_();
    idle();
    chk_o("post_reset", 8'b1010_0001);
  endtask

  task automatic test_back_to_back();
    drive(3'b110, 32'h7FFF_FFFF, 0, 0, 0, 0);
    edge_();
    chk_o("b2b_1", 8'b0000_0001);
    drive(3'b010, 32'hFFFF_FFFF, 1, 0, 1, 0);
    edge_();
    chk_o("b2b_2", 8'b0100_0001);
    drive(3'b110, 32'h0, 1, 0, 0, 1);
    edge_();
    idle();
    chk_o("b2b_3", 8'b1011_1011);
  endtask

  initial begin
    idle();
    cond = 4'h0;
    reset_n = 0;
    test_reset();
    test_add_ovf();
    test_sub_zero();
    test_logic_hold();
    test_cond_table();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
